// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO and byte launcher feeding a UART transmitter.
// Host bytes are buffered in a synchronous FIFO. One byte at a time is popped
// onto tx_din, launched with a single-cycle tx_start, and the block then waits
// for tx_done before it launches the next byte.
module uart_tx_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DATA_WIDTH-1:0]    tx_din,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_tx_din;
  logic                  r_tx_start;
  logic                  r_busy;

  logic                  w_wr_accept;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nxt;

  // A full FIFO rejects writes even when a pop happens in the same cycle.
  assign w_wr_accept = wr_en && !r_full;

  // Next-state decode; the pop happens only on the IDLE-to-START transition.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START:     w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Occupancy after this edge: a simultaneous accepted write and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_accept && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_wr_accept && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept)
      r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers, occupancy flags and the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)       r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= wr_en && r_full;
    end
  end

  // Launch outputs: tx_din holds from one pop to the next, tx_start marks START.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_din   <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) begin
        r_tx_din <= r_mem[r_rd_ptr];
        r_busy   <= 1'b1;
      end else if (r_state == WAIT_DONE && tx_done) begin
        r_busy   <= 1'b0;
      end
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_din   = r_tx_din;
  assign tx_start = r_tx_start;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl: a fixed vector table, directed
// multi-cycle sequences, and a randomized run, all checked against a
// queue-based reference model.
module tb_uart_tx_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic [DW-1:0] tx_din;
  logic          tx_start;
  logic          tx_done;
  logic          busy;

  uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_din   (tx_din),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue, plus the age of the current
  // launch (-1 = nothing in flight, 0 = launch cycle, >=1 = awaiting done).
  logic [DW-1:0] m_q[$];
  int            m_age = -1;
  logic [DW-1:0] m_din = '0;
  bit            m_ovf = 1'b0;
  bit            m_acc = 1'b0;

  logic [DW-1:0] cap[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit we, input logic [DW-1:0] wd, input bit done);
    int n;
    if (r) begin
      m_q.delete();
      m_age = -1;
      m_din = '0;
      m_ovf = 1'b0;
      m_acc = 1'b0;
    end else begin
      n     = m_q.size();
      m_acc = we && (n < DEPTH);
      m_ovf = we && (n == DEPTH);
      if (m_age < 0 && n > 0) begin
        m_din = m_q.pop_front();
        m_age = 0;
      end else if (m_age >= 0) begin
        if (m_age >= 1 && done) m_age = -1;
        else                    m_age = m_age + 1;
      end
      if (m_acc) m_q.push_back(wd);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic cycle(input bit r, input bit we, input logic [DW-1:0] wd, input bit done);
    rst     = r;
    wr_en   = we;
    wr_data = wd;
    tx_done = done;
    @(posedge clk);
    model_edge(r, we, wd, done);
    #1;
    chk("count",    count,    m_q.size());
    chk("empty",    empty,    m_q.size() == 0);
    chk("full",     full,     m_q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("tx_start", tx_start, m_age == 0);
    chk("busy",     busy,     m_age >= 0);
    chk("tx_din",   tx_din,   m_din);
    if (tx_start === 1'b1) cap.push_back(tx_din);
  endtask

  typedef struct {
    bit            r;
    bit            we;
    logic [DW-1:0] wd;
    bit            done;
    int            e_cnt;
    bit            e_emp;
    bit            e_ful;
    bit            e_st;
    bit            e_bsy;
    logic [DW-1:0] e_din;
    bit            e_ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int            n_sent;
    int            lat;
    int            cyc;
    bit            dn;
    bit            we;
    logic [DW-1:0] wd;
    logic [DW-1:0] sent[$];

    //         rst we  wd    done cnt emp ful st bsy din   ovf
    tbl[0]  = '{1, 0, 8'h00, 0,  0,  1,  0,  0, 0, 8'h00, 0};
    tbl[1]  = '{0, 1, 8'hA5, 0,  1,  0,  0,  0, 0, 8'h00, 0};
    tbl[2]  = '{0, 0, 8'h00, 0,  0,  1,  0,  1, 1, 8'hA5, 0};
    tbl[3]  = '{0, 0, 8'h00, 0,  0,  1,  0,  0, 1, 8'hA5, 0};
    tbl[4]  = '{0, 0, 8'h00, 0,  0,  1,  0,  0, 1, 8'hA5, 0};
    tbl[5]  = '{0, 0, 8'h00, 1,  0,  1,  0,  0, 0, 8'hA5, 0};
    tbl[6]  = '{0, 0, 8'h00, 0,  0,  1,  0,  0, 0, 8'hA5, 0};
    tbl[7]  = '{0, 0, 8'h00, 1,  0,  1,  0,  0, 0, 8'hA5, 0};
    tbl[8]  = '{0, 1, 8'h3C, 0,  1,  0,  0,  0, 0, 8'hA5, 0};
    tbl[9]  = '{0, 1, 8'hC3, 0,  1,  0,  0,  1, 1, 8'h3C, 0};
    tbl[10] = '{0, 0, 8'h00, 1,  1,  0,  0,  0, 1, 8'h3C, 0};
    tbl[11] = '{0, 0, 8'h00, 0,  1,  0,  0,  0, 1, 8'h3C, 0};
    tbl[12] = '{0, 0, 8'h00, 1,  1,  0,  0,  0, 0, 8'h3C, 0};
    tbl[13] = '{0, 0, 8'h00, 0,  0,  1,  0,  1, 1, 8'hC3, 0};
    tbl[14] = '{1, 0, 8'h00, 0,  0,  1,  0,  0, 0, 8'h00, 0};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_done = 1'b0;

    // Vector table: single byte launch, done ignored in IDLE/START, write+pop.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r, tbl[i].we, tbl[i].wd, tbl[i].done);
      chk($sformatf("tbl%0d_count", i), count,    tbl[i].e_cnt);
      chk($sformatf("tbl%0d_empty", i), empty,    tbl[i].e_emp);
      chk($sformatf("tbl%0d_full", i),  full,     tbl[i].e_ful);
      chk($sformatf("tbl%0d_start", i), tx_start, tbl[i].e_st);
      chk($sformatf("tbl%0d_busy", i),  busy,     tbl[i].e_bsy);
      chk($sformatf("tbl%0d_din", i),   tx_din,   tbl[i].e_din);
      chk($sformatf("tbl%0d_ovf", i),   overflow, tbl[i].e_ovf);
    end

    // Reset then idle: nothing launches.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 8'h00, 0);
      chk("idle_start", tx_start, 0);
      chk("idle_din",   tx_din,   0);
    end

    // Fill to full with done held off, then overflow, then drain in order.
    cap.delete();
    for (int b = 1; b <= 18; b++) begin
      cycle(0, 1, 8'(b), 0);
      if (b == 17) begin
        chk("fill_count16", count, 16);
        chk("fill_full",    full,  1);
      end
      if (b == 18) begin
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count,    16);
      end
    end
    cycle(0, 0, 8'h00, 0);
    chk("ovf_cleared", overflow, 0);
    for (int k = 0; k < 17; k++) begin
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 0);
    chk("drain_empty", empty, 1);
    chk("drain_n", cap.size(), 17);
    for (int i = 0; i < 17 && i < cap.size(); i++)
      chk($sformatf("drain_byte%0d", i), cap[i], i + 1);

    // Randomized traffic with random done latency; order must be preserved.
    cycle(1, 0, 8'h00, 0);
    cap.delete();
    n_sent = 0; lat = 0; cyc = 0;
    while (cyc < 6000 && !(n_sent == 40 && cap.size() == 40 && busy === 1'b0)) begin
      we = (n_sent < 40) && ($urandom_range(0, 1) == 1);
      wd = 8'($urandom);
      dn = (lat == 1);
      cycle(0, we, wd, dn);
      if (m_acc) begin
        sent.push_back(wd);
        n_sent++;
      end
      if (lat > 0) lat--;
      if (tx_start === 1'b1) lat = $urandom_range(2, 20);
      cyc++;
    end
    chk("rand_launched", cap.size(), 40);
    for (int i = 0; i < 40 && i < cap.size() && i < sent.size(); i++)
      chk($sformatf("rand_order%0d", i), cap[i], sent[i]);

    // Reset while waiting for done with five bytes queued.
    cycle(1, 0, 8'h00, 0);
    for (int b = 0; b < 6; b++) cycle(0, 1, 8'(8'h60 + b), 0);
    cycle(0, 0, 8'h00, 0);
    chk("mid_count5", count, 5);
    chk("mid_busy",   busy,  1);
    cycle(1, 0, 8'h00, 0);
    chk("rst_count", count,    0);
    chk("rst_empty", empty,    1);
    chk("rst_busy",  busy,     0);
    chk("rst_din",   tx_din,   0);
    chk("rst_start", tx_start, 0);
    cycle(0, 0, 8'h00, 1);
    chk("post_done_busy",  busy,     0);
    chk("post_done_start", tx_start, 0);
    chk("post_done_count", count,    0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
